// File: rtl/serial_adder.sv
// Serial (digit-serial) adder/subtractor.
// Adds two WIDTH-bit operands DIGIT bits per clock using a ripple of
// full-adder cells. A subtraction is A + ~B + 1. The result, carry-out and
// two's-complement overflow are held until the next accepted start.
// WIDTH must be a multiple of DIGIT, and WIDTH must be at least 2.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [IW-1:0]    bit_idx;
  logic [DIGIT-1:0] x_dig;
  logic [DIGIT-1:0] y_dig;
  logic [DIGIT+1:0] add_res;
  logic [DIGIT-1:0] s_dig;
  logic             c_out_dig;
  logic             c_msb_dig;
  logic             last_dig;

  // Ripple of full-adder cells over one digit.
  // Returns {carry into the top bit, carry out of the top bit, sum bits}.
  function automatic logic [DIGIT+1:0] add_digit(
    input logic [DIGIT-1:0] x,
    input logic [DIGIT-1:0] y,
    input logic             c
  );
    logic             c_cur;
    logic             c_in_top;
    logic [DIGIT-1:0] s;
    c_cur    = c;
    c_in_top = c;
    s        = '0;
    for (int i = 0; i < DIGIT; i++) begin
      c_in_top = c_cur;
      s[i]     = x[i] ^ y[i] ^ c_cur;
      c_cur    = (x[i] & y[i]) | (y[i] & c_cur) | (x[i] & c_cur);
    end
    return {c_in_top, c_cur, s};
  endfunction

  // Select the current digit of both operands and add it to the carry.
  always_comb begin
    bit_idx   = IW'(cnt) * IW'(DIGIT);
    x_dig     = a_reg[bit_idx +: DIGIT];
    y_dig     = b_reg[bit_idx +: DIGIT];
    add_res   = add_digit(x_dig, y_dig, carry);
    s_dig     = add_res[DIGIT-1:0];
    c_out_dig = add_res[DIGIT];
    c_msb_dig = add_res[DIGIT+1];
    last_dig  = (cnt == CW'(NDIG - 1));
  end

  // Control FSM with registered busy/done and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Operands and mode are frozen here; later input changes are ignored.
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          sum[bit_idx +: DIGIT] <= s_dig;
          carry                 <= c_out_dig;
          cnt                   <= cnt + CW'(1);
          if (last_dig) begin
            cout     <= c_out_dig;
            overflow <= c_out_dig ^ c_msb_dig;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder: an 8-bit bit-serial
// instance and a 16-bit instance processing 4 bits per cycle.
module tb_serial_adder;

  logic clk;
  logic rst;

  logic        start8, cin8, sub8, busy8, done8, cout8, ov8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, cin16, sub16, busy16, done16, cout16, ov16;
  logic [15:0] a16, b16, sum16;

  int n_checks;
  int n_pass;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ov8)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ov16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One 8-bit operation: latency, busy length, no busy/done overlap, result, pulse width.
  task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                     input logic tc, input logic ts,
                     input logic [7:0] esum, input logic ec, input logic eo);
    int cyc;
    int bcnt;
    int both;
    a8 = ta; b8 = tb; cin8 = tc; sub8 = ts; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc = 1; bcnt = 0; both = 0;
    while (!done8 && cyc < 40) begin
      if (busy8) bcnt++;
      @(posedge clk); #1;
      cyc++;
    end
    if (done8 && busy8) both++;
    check({tag, "_lat"}, cyc, 9);
    check({tag, "_busy"}, bcnt, 8);
    check({tag, "_overlap"}, both, 0);
    check({tag, "_sum"}, {24'd0, sum8}, {24'd0, esum});
    check({tag, "_cout"}, {31'd0, cout8}, {31'd0, ec});
    check({tag, "_ovf"}, {31'd0, ov8}, {31'd0, eo});
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'd0, done8}, 32'd0);
    check({tag, "_hold"}, {24'd0, sum8}, {24'd0, esum});
  endtask

  initial begin
    int cyc;
    int dcnt;
    logic [7:0] got8;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; sub8 = 1'b0;
    start16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0; sub16 = 1'b0;
    #3;
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_sum", {24'd0, sum8}, 32'd0);
    check("rst_cout", {31'd0, cout8}, 32'd0);
    check("rst_ovf", {31'd0, ov8}, 32'd0);
    check("rst_sum16", {16'd0, sum16}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // First start immediately after reset release.
    op8("ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    op8("cin", 8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0);
    // 5 - 7 = -2; cin must be ignored in subtract mode.
    op8("sub57", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    op8("sub75", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);

    // Start pulse with new operands 3 cycles into RUN must be ignored.
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    dcnt = 0; got8 = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin
        dcnt++;
        got8 = sum8;
      end
      if (i == 2) begin
        start8 = 1'b1; a8 = 8'h00; b8 = 8'h00;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("ign_done_cnt", dcnt, 1);
    check("ign_sum", {24'd0, got8}, 32'h46);

    // Reset 4 cycles into RUN: outputs clear before any clock edge, no done follows.
    a8 = 8'h55; b8 = 8'h22; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #1 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy8}, 32'd0);
    check("arst_sum", {24'd0, sum8}, 32'd0);
    check("arst_cout", {31'd0, cout8}, 32'd0);
    check("arst_done", {31'd0, done8}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8 || busy8) dcnt++;
      @(posedge clk); #1;
    end
    check("arst_no_done", dcnt, 0);
    op8("after_rst", 8'h55, 8'h22, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0);

    // 16-bit, 4 bits per cycle, with a back-to-back start while done is high.
    a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    cyc = 1;
    while (!done16 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("w16_lat", cyc, 5);
    check("w16_sum", {16'd0, sum16}, 32'h0000);
    check("w16_cout", {31'd0, cout16}, 32'd1);
    a16 = 16'h1234; b16 = 16'h1111; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    check("b2b_busy", {31'd0, busy16}, 32'd1);
    cyc = 1;
    while (!done16 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_lat", cyc, 5);
    check("b2b_sum", {16'd0, sum16}, 32'h2345);
    check("b2b_cout", {31'd0, cout16}, 32'd0);

    // 16-bit subtract: 0x1234 - 0x1111.
    a16 = 16'h1234; b16 = 16'h1111; sub16 = 1'b1; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    cyc = 1;
    while (!done16 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("s16_lat", cyc, 5);
    check("s16_sum", {16'd0, sum16}, 32'h0123);
    check("s16_cout", {31'd0, cout16}, 32'd1);
    check("s16_ovf", {31'd0, ov16}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
